// File: rtl/cache_pkg.sv
// Shared cache encodings and default geometry for the snoop responder and
// the tag/data array.
package cache_pkg;
  localparam int ADDR_BITS  = 32;
  localparam int INDEX_BITS = 14;
  localparam int TAG_BITS   = 12;
  localparam int LINE_SIZE  = 512;
  localparam int WAYS       = 8;
  localparam int BUS_WIDTH  = 64;

  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INVALIDATE = 2'd2, OP_RWIM = 2'd3} snoop_op_e;
  typedef enum logic [1:0] {RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2} snoop_res_e;

  typedef struct packed {
    logic [1:0]           op;
    logic [ADDR_BITS-1:0] addr;
  } snoop_req_t;

  // Clears the byte-offset bits so the address points at the start of the line.
  function automatic logic [ADDR_BITS-1:0] line_base(input logic [ADDR_BITS-1:0] addr,
                                                     input int off_bits);
    return addr & ~((ADDR_BITS'(1) << off_bits) - ADDR_BITS'(1));
  endfunction
endpackage

// File: rtl/wb_serializer.sv
// Buffers one cache line and streams it out as bus-width beats with
// valid/ready handshaking; beat n goes to line base + n * beat bytes.
module wb_serializer #(
  parameter int lineSize = 512,
  parameter int busWidth = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [lineSize-1:0] line_in,
  input  logic [31:0]         base_in,
  input  logic                active,
  input  logic                wb_ready,
  output logic                wb_valid,
  output logic [busWidth-1:0] wb_data,
  output logic [31:0]         wb_addr,
  output logic                wb_last,
  output logic                done
);
  localparam int BEATS = lineSize / busWidth;
  localparam int CW    = $clog2(BEATS);
  localparam int BSH   = $clog2(busWidth / 8);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [lineSize-1:0] line_q;
  logic [31:0]         base_q;
  logic [CW-1:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      base_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      line_q <= line_in;
      base_q <= base_in;
      cnt    <= '0;
    end else if (active && wb_ready) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Outputs read zero when idle so nothing stale shows on the bus.
  assign wb_valid = active;
  assign wb_data  = active ? line_q[int'(cnt) * busWidth +: busWidth] : '0;
  assign wb_addr  = active ? base_q + (32'(cnt) << BSH) : '0;
  assign wb_last  = active && (cnt == LAST);
  assign done     = active && wb_ready && (cnt == LAST);
endmodule

// File: rtl/snoop_responder.sv
// Bus snoop responder: looks up the snooped line, answers NOHIT/HIT/HITM,
// writes back modified lines and updates the MESI state.
module snoop_responder import cache_pkg::*; #(
  parameter int indexBits = INDEX_BITS,
  parameter int tagBits   = TAG_BITS,
  parameter int lineSize  = LINE_SIZE,
  parameter int ways      = WAYS,
  parameter int busWidth  = BUS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     snoop_valid,
  output logic                     snoop_ready,
  input  logic [1:0]               snoop_op,
  input  logic [31:0]              snoop_addr,
  output logic                     lookup_req,
  output logic [indexBits-1:0]     lookup_index,
  output logic [tagBits-1:0]       lookup_tag,
  input  logic                     lookup_ack,
  input  logic                     lookup_hit,
  input  logic [$clog2(ways)-1:0]  lookup_way,
  input  logic [1:0]               lookup_mesi,
  input  logic [lineSize-1:0]      lookup_data,
  output logic                     update_req,
  output logic [indexBits-1:0]     update_index,
  output logic [$clog2(ways)-1:0]  update_way,
  output logic [1:0]               update_mesi,
  input  logic                     update_ack,
  output logic                     result_valid,
  output logic [1:0]               snoop_result,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [busWidth-1:0]      wb_data,
  output logic [31:0]              wb_addr,
  output logic                     wb_last
);
  localparam int WW  = $clog2(ways);
  localparam int OFF = 32 - tagBits - indexBits;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_RESULT = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  logic [2:0]    state;
  snoop_req_t    req_q;
  logic [WW-1:0] way_q;
  logic [1:0]    res_q, nmesi_q;
  logic          upd_q;
  logic [1:0]    tbl_res, tbl_mesi;
  logic          tbl_upd;
  logic          accept, wb_done;

  assign accept = snoop_valid && snoop_ready;

  // Response/next-state table; misses and Invalid lines answer NOHIT untouched.
  always_comb begin
    tbl_res  = RES_NOHIT;
    tbl_mesi = MESI_I;
    tbl_upd  = 1'b0;
    if (lookup_hit && lookup_mesi != MESI_I) begin
      case (req_q.op)
        OP_READ: begin
          tbl_res  = (lookup_mesi == MESI_M) ? RES_HITM : RES_HIT;
          tbl_mesi = MESI_S;
          tbl_upd  = (lookup_mesi != MESI_S);
        end
        OP_INVALIDATE: begin
          tbl_res = RES_HIT;
          tbl_upd = 1'b1;
        end
        OP_RWIM: begin
          tbl_res = (lookup_mesi == MESI_M) ? RES_HITM : RES_HIT;
          tbl_upd = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= '0;
      way_q   <= '0;
      res_q   <= RES_NOHIT;
      nmesi_q <= MESI_I;
      upd_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          req_q <= '{op: snoop_op, addr: snoop_addr};
          res_q <= RES_NOHIT;
          upd_q <= 1'b0;
          state <= (snoop_op == OP_WRITE) ? S_RESULT : S_LOOKUP;
        end
        S_LOOKUP: if (lookup_ack) begin
          way_q   <= lookup_way;
          res_q   <= tbl_res;
          nmesi_q <= tbl_mesi;
          upd_q   <= tbl_upd;
          state   <= S_RESULT;
        end
        S_RESULT: state <= (res_q == RES_HITM) ? S_WB : (upd_q ? S_UPDATE : S_IDLE);
        S_WB:     if (wb_done) state <= S_UPDATE;
        S_UPDATE: if (update_ack) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign snoop_ready  = (state == S_IDLE);
  assign lookup_req   = (state == S_LOOKUP);
  assign lookup_index = req_q.addr[OFF +: indexBits];
  assign lookup_tag   = req_q.addr[31 -: tagBits];
  assign result_valid = (state == S_RESULT);
  assign snoop_result = res_q;
  assign update_req   = (state == S_UPDATE);
  assign update_index = lookup_index;
  assign update_way   = way_q;
  assign update_mesi  = nmesi_q;

  wb_serializer #(.lineSize(lineSize), .busWidth(busWidth)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .load     (lookup_req && lookup_ack),
    .line_in  (lookup_data),
    .base_in  (line_base(req_q.addr, OFF)),
    .active   (state == S_WB),
    .wb_ready (wb_ready),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_addr  (wb_addr),
    .wb_last  (wb_last),
    .done     (wb_done)
  );
endmodule

// File: tb/tb_snoop_responder.sv
// Directed and randomized snoops against a table-driven reference model of
// the MESI response rules and writeback beat ordering.
module tb_snoop_responder;
  import cache_pkg::*;

  logic         clk = 0, rst = 1;
  logic         snoop_valid = 0, snoop_ready;
  logic [1:0]   snoop_op = 0;
  logic [31:0]  snoop_addr = 0;
  logic         lookup_req, lookup_ack = 0, lookup_hit = 0;
  logic [13:0]  lookup_index, update_index;
  logic [11:0]  lookup_tag;
  logic [2:0]   lookup_way = 0, update_way;
  logic [1:0]   lookup_mesi = 0, update_mesi, snoop_result;
  logic [511:0] lookup_data = '0;
  logic         update_req, update_ack = 0, result_valid;
  logic         wb_valid, wb_ready = 0, wb_last;
  logic [63:0]  wb_data;
  logic [31:0]  wb_addr;

  int ncomp = 0, nfail = 0;

  always #5 clk = ~clk;

  snoop_responder dut (
    .clk(clk), .rst(rst),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .lookup_req(lookup_req), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .lookup_ack(lookup_ack), .lookup_hit(lookup_hit), .lookup_way(lookup_way),
    .lookup_mesi(lookup_mesi), .lookup_data(lookup_data),
    .update_req(update_req), .update_index(update_index), .update_way(update_way),
    .update_mesi(update_mesi), .update_ack(update_ack),
    .result_valid(result_valid), .snoop_result(snoop_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr), .wb_last(wb_last)
  );

  // Reference table [op][mesi] = {result, next mesi, update needed}, valid for hits.
  localparam logic [4:0] TAB [4][4] = '{
    '{5'b00_00_0, 5'b01_01_0, 5'b01_01_1, 5'b10_01_1},  // READ
    '{5'b00_00_0, 5'b00_00_0, 5'b00_00_0, 5'b00_00_0},  // WRITE
    '{5'b00_00_0, 5'b01_00_1, 5'b01_00_1, 5'b01_00_1},  // INVALIDATE
    '{5'b00_00_0, 5'b01_00_1, 5'b01_00_1, 5'b10_00_1}   // RWIM
  };

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_snoop(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                          input logic [2:0] way, input logic [1:0] mesi, input int dly,
                          input int mode, input int abort_at);
    logic [511:0] line;
    logic [4:0]   ent;
    logic [1:0]   eres, emesi;
    logic         eupd, r;
    int           n, guard;
    for (int i = 0; i < 16; i++) line[32*i +: 32] = $urandom;
    ent   = hit ? TAB[op][mesi] : 5'b0;
    eres  = ent[4:3];
    emesi = ent[2:1];
    eupd  = ent[0];

    chk("ready_idle", snoop_ready, 1);
    snoop_valid = 1; snoop_op = op; snoop_addr = addr;
    @(negedge clk);
    snoop_valid = 0; snoop_addr = $urandom;
    if (op == OP_WRITE) begin
      chk("write_result_valid", result_valid, 1);
      chk("write_result", snoop_result, RES_NOHIT);
      chk("write_no_lookup", lookup_req, 0);
      @(negedge clk);
      chk("write_ready_back", snoop_ready, 1);
      chk("write_no_lookup2", lookup_req, 0);
      return;
    end
    chk("lookup_req", lookup_req, 1);
    chk("lookup_index", lookup_index, addr[19:6]);
    chk("lookup_tag", lookup_tag, addr[31:20]);
    repeat (dly) begin
      update_ack = 1'($urandom_range(0, 1));
      wb_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("lookup_hold", lookup_req, 1);
      chk("lookup_index_hold", lookup_index, addr[19:6]);
      chk("lookup_tag_hold", lookup_tag, addr[31:20]);
      chk("no_early_result", result_valid, 0);
    end
    update_ack = 0; wb_ready = 0;
    lookup_ack = 1; lookup_hit = hit; lookup_way = way; lookup_mesi = mesi; lookup_data = line;
    @(negedge clk);
    lookup_ack = 0; lookup_hit = 1'($urandom); lookup_mesi = 2'($urandom); lookup_data = '0;
    chk("result_valid", result_valid, 1);
    chk("snoop_result", snoop_result, eres);
    chk("lookup_dropped", lookup_req, 0);
    @(negedge clk);
    chk("result_pulse", result_valid, 0);
    if (eres == RES_HITM) begin
      n = 0; guard = 0;
      while (n < 8 && guard < 100) begin
        if (abort_at == n) begin
          rst = 1; snoop_valid = 1; wb_ready = 0;
          @(negedge clk);
          chk("rst_wb_valid", wb_valid, 0);
          chk("rst_update_req", update_req, 0);
          chk("rst_lookup_req", lookup_req, 0);
          chk("rst_wb_data", wb_data, 0);
          rst = 0; snoop_valid = 0;
          @(negedge clk);
          chk("rst_ready", snoop_ready, 1);
          chk("rst_no_lookup", lookup_req, 0);
          return;
        end
        chk("wb_valid", wb_valid, 1);
        chk("wb_data", wb_data, line[64*n +: 64]);
        chk("wb_addr", wb_addr, {addr[31:6], 6'b0} + 32'(8 * n));
        chk("wb_last", wb_last, n == 7);
        case (mode)
          0:       r = 1;
          1:       r = (guard % 2 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        wb_ready = r;
        @(negedge clk);
        if (r) n++;
        guard++;
      end
      wb_ready = 0;
      chk("wb_beat_count", 64'(n), 8);
      chk("wb_done", wb_valid, 0);
    end else begin
      chk("no_wb", wb_valid, 0);
    end
    if (eupd) begin
      chk("update_req", update_req, 1);
      chk("update_index", update_index, addr[19:6]);
      chk("update_way", update_way, way);
      chk("update_mesi", update_mesi, emesi);
      repeat ($urandom_range(0, 3)) begin
        lookup_ack = 1'($urandom);
        @(negedge clk);
        chk("update_hold", update_req, 1);
        chk("update_mesi_hold", update_mesi, emesi);
      end
      lookup_ack = 0; update_ack = 1;
      @(negedge clk);
      update_ack = 0;
    end else begin
      chk("no_update", update_req, 0);
    end
    chk("ready_back", snoop_ready, 1);
    chk("update_clear", update_req, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", snoop_ready, 1);
    chk("rst_lookup_req", lookup_req, 0);
    chk("rst_update_req", update_req, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", snoop_result, RES_NOHIT);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_last", wb_last, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_lookup_index", lookup_index, 0);
    chk("rst_update_mesi", update_mesi, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", snoop_ready, 1);

    do_snoop(OP_READ,       32'h0001_2340, 1, 3'd5, MESI_M, 0, 0, -1);
    do_snoop(OP_RWIM,       32'h0ABC_1D40, 1, 3'd2, MESI_E, 1, 0, -1);
    do_snoop(OP_INVALIDATE, 32'h0ABC_1D40, 0, 3'd2, MESI_E, 0, 0, -1);
    do_snoop(OP_READ,       32'h7654_3210, 1, 3'd1, MESI_S, 2, 0, -1);
    do_snoop(OP_WRITE,      32'h1111_2222, 1, 3'd0, MESI_M, 0, 0, -1);
    do_snoop(OP_READ,       32'hFFFF_FFC0, 1, 3'd7, MESI_M, 1, 1, -1);
    do_snoop(OP_RWIM,       32'h0042_0080, 1, 3'd3, MESI_M, 0, 0, 3);
    do_snoop(OP_READ,       32'h0042_0080, 1, 3'd3, MESI_E, 0, 0, -1);
    do_snoop(OP_INVALIDATE, 32'h3003_0000, 1, 3'd6, MESI_S, 10, 0, -1);
    do_snoop(OP_INVALIDATE, 32'h3003_0000, 1, 3'd6, MESI_M, 0, 0, -1);
    do_snoop(OP_READ,       32'h3003_0000, 1, 3'd6, MESI_I, 0, 0, -1);

    for (int k = 0; k < 30; k++)
      do_snoop(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) != 0,
               3'($urandom), 2'($urandom), $urandom_range(0, 4), $urandom_range(0, 2), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", ncomp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 Parameter indexBits, 14, set index width.
REQ-002 Parameter tagBits, 12, tag width.
REQ-003 Parameter lineSize, 512, line width in bits.
REQ-004 Parameter ways, 8, associativity; way fields are $clog2(ways) wide.
REQ-005 Parameter busWidth, 64, writeback beat width; beats per line = lineSize/busWidth.
REQ-006 clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-007 snoop_valid in 1, snoop_ready out 1, snoop_op in 2 (READ=0, WRITE=1, INVALIDATE=2, RWIM=3), snoop_addr in 32: snooped bus operation; address = tag|index|6-bit offset.
REQ-008 lookup_req out 1, lookup_index out indexBits, lookup_tag out tagBits, lookup_ack in 1, lookup_hit in 1, lookup_way in $clog2(ways), lookup_mesi in 2, lookup_data in lineSize: tag/data array query.
REQ-009 update_req out 1, update_index out indexBits, update_way out $clog2(ways), update_mesi out 2, update_ack in 1: MESI state write.
REQ-010 result_valid out 1, snoop_result out 2 (NOHIT=0, HIT=1, HITM=2): snoop response to bus.
REQ-011 wb_valid out 1, wb_ready in 1, wb_data out busWidth, wb_addr out 32, wb_last out 1: modified-line writeback.

Function
REQ-012 FSM states IDLE, LOOKUP, RESULT, WRITEBACK, UPDATE; snoop_ready = 1 only in IDLE.
REQ-013 IDLE: on snoop_valid&snoop_ready capture op/addr; WRITE -> RESULT; any other op -> LOOKUP.
REQ-014 LOOKUP: lookup_req held high with stable index/tag until lookup_ack; on ack capture hit, way, mesi, data; -> RESULT.
REQ-015 RESULT: result_valid pulses exactly one cycle; then -> WRITEBACK if result HITM, else -> UPDATE if MESI changes, else -> IDLE.
REQ-016 Response table (miss or I -> NOHIT, no update): READ M->HITM/S, E->HIT/S, S->HIT/S(no update); INVALIDATE any valid->HIT/I; RWIM M->HITM/I, E or S->HIT/I; WRITE always NOHIT, no lookup.
REQ-017 WRITEBACK: 8 beats; beat n carries data[64n+63:64n], wb_addr = line address + 8n; beat transfers on wb_valid&wb_ready; wb_data/wb_addr stable while wb_valid&!wb_ready; wb_last only on beat 7; after beat 7 -> UPDATE.
REQ-018 Beat counter 3 bits, wraps to 0 after last beat, never exceeds 7.
REQ-019 UPDATE: update_req held with stable index/way/mesi until update_ack; -> IDLE same edge as ack.
REQ-020 Latency: accept edge T -> lookup_req high T+1; ack edge A -> result_valid in cycle A+1; WRITE op -> result_valid T+1, snoop_ready T+2.
REQ-021 lookup_ack/update_ack outside their states are ignored; wb_ready ignored outside WRITEBACK.
REQ-022 Only one snoop outstanding; no new acceptance until return to IDLE.

Reset
REQ-023 On rst: FSM IDLE, counter 0, all req/valid/last outputs 0, snoop_result NOHIT, data/address outputs 0; applies mid-operation, aborting any lookup, writeback or update next edge.
REQ-024 rst wins over simultaneous snoop_valid; snoop_ready reads 1 in first cycle after rst deasserts.

Structure
REQ-025 Shared package cache_pkg holds MESI encoding (I=0, S=1, E=2, M=3), snoop_op and snoop_result encodings, default widths; used by the cache array block.
REQ-026 One sub-module, wb_serializer (line buffer + beat counter + valid/ready), is natural; FSM and MESI table stay in snoop_responder.

Verification
REQ-027 READ addr 0x0001_2340, ack hit way 5 mesi=M, wb_ready=1 -> HITM, 8 beats addr 0x0001_2340..0x0001_2378, wb_last beat 7, update way 5 mesi=S.
REQ-028 RWIM, hit mesi=E -> HIT, no writeback, update mesi=I; then INVALIDATE same line, miss -> NOHIT, no update_req.
REQ-029 READ hit S -> HIT, no update_req, snoop_ready returns cycle after result; WRITE -> NOHIT at T+1, no lookup_req.
REQ-030 HITM writeback with wb_ready toggling 1/0 each cycle -> each beat held stable, exactly 8 transfers, correct order.
REQ-031 rst asserted during beat 3 of writeback -> next cycle wb_valid=0, update_req=0, snoop_ready=1 after release; new snoop processed normally.
REQ-032 lookup_ack delayed 10 cycles with ignored update_ack pulse -> lookup_req stays high, inputs stable, no spurious transition.
